ifu_fetch: RTL and testbench

- Instruction fetch stage directly upstream of decode and immediate sign-extension.
- Holds the PC and issues one 32-bit fetch at a time to instruction memory over a valid/ready request plus valid response.
- Presents the fetched instruction and its PC to decode with a valid/ready handshake; decode extracts the immediate field from it.
- Accepts redirects from branch/jump resolution (targets computed from the sign-extended immediate) and discards stale in-flight fetches.

---
 rtl/ifu_fetch_pkg.sv | 15 +
 rtl/ifu_fetch.sv | 130 +++++++++++++
 tb/tb_ifu_fetch.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  // Canonical addi x0,x0,0; reserved for bubble insertion once fetch is pipelined.
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request, redirect handling with stale-response
// kill, and a valid/ready hand-off of instruction + PC to decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              imem_resp_err,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_fault
);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic              fault_q, fault_d;
  logic              redirect_misaligned;

  assign redirect_misaligned = redirect_pc[1:0] != 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StReq;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      kill_q    <= kill_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;

    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (redirect_misaligned) begin
        // Fault is delivered locally; memory is never asked for this address.
        state_d   = StHold;
        kill_d    = 1'b0;
        inst_d    = '0;
        inst_pc_d = redirect_pc;
        fault_d   = 1'b1;
      end else begin
        unique case (state_q)
          StReq: begin
            if (imem_req_ready) begin
              state_d = StWait;
              kill_d  = 1'b1;
            end
          end
          StWait: begin
            if (imem_resp_valid) begin
              state_d = StReq;
              kill_d  = 1'b0;
            end else begin
              kill_d = 1'b1;
            end
          end
          StHold:  state_d = StReq;
          default: state_d = StReq;
        endcase
      end
    end else begin
      unique case (state_q)
        StReq: begin
          if (imem_req_ready) state_d = StWait;
        end
        StWait: begin
          if (imem_resp_valid) begin
            if (kill_q) begin
              state_d = StReq;
              kill_d  = 1'b0;
            end else begin
              state_d   = StHold;
              inst_d    = imem_resp_err ? '0 : imem_resp_data;
              inst_pc_d = pc_q;
              fault_d   = imem_resp_err;
            end
          end
        end
        StHold: begin
          if (inst_ready) begin
            state_d = StReq;
            pc_d    = pc_q + XLEN'(4);
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_comb begin
    // Gate with rst_n: reset forces StReq, but no request may be presented while held in reset.
    imem_req_valid = (state_q == StReq) && rst_n;
    imem_req_addr  = pc_q;
    inst_valid     = state_q == StHold;
    inst           = inst_q;
    inst_pc        = inst_pc_q;
    inst_fault     = fault_q;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch; memory and decode are driven cycle by cycle.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        imem_resp_err = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;

  int n_vec = 0;
  int n_err = 0;

  ifu_fetch #(
    .XLEN    (64),
    .RESET_PC(64'h0000_0000_8000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({imem_req_valid, inst_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_valids: got %b want 00", {imem_req_valid, inst_valid});
    end
    n_vec++;
    if ({inst, inst_pc, inst_fault} !== 97'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got inst=%h pc=%h flt=%b want all 0", inst, inst_pc,
               inst_fault);
    end
    n_vec++;
    if (imem_req_addr !== 64'h8000_0000) begin
      n_err++;
      $display("FAIL reset_pc: got %h want 0000000080000000", imem_req_addr);
    end
    tick();
    tick();
    n_vec++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held_req: got %b want 0", imem_req_valid);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0000}) begin
      n_err++;
      $display("FAIL release_req: got v=%b a=%h want v=1 a=80000000", imem_req_valid,
               imem_req_addr);
    end
  endtask

  task automatic test_basic_fetch();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    n_vec++;
    if ({imem_req_valid, inst_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_wait: got %b want 00", {imem_req_valid, inst_valid});
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    n_vec++;
    if ({inst_valid, inst_fault, inst, inst_pc} !== {2'b10, 32'h13, 64'h8000_0000}) begin
      n_err++;
      $display("FAIL basic_deliver: got v=%b f=%b i=%h pc=%h want v=1 f=0 i=13 pc=80000000",
               inst_valid, inst_fault, inst, inst_pc);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if ({inst_valid, imem_req_valid, inst, inst_pc} !== {2'b10, 32'h13, 64'h8000_0000}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b rq=%b i=%h pc=%h want 1 0 13 80000000", i,
                 inst_valid, imem_req_valid, inst, inst_pc);
      end
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_vec++;
    if ({imem_req_valid, inst_valid, imem_req_addr} !== {2'b10, 64'h8000_0004}) begin
      n_err++;
      $display("FAIL stall_consume: got rq=%b v=%b a=%h want 1 0 80000004", imem_req_valid,
               inst_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    n_vec++;
    if ({imem_req_valid, inst_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rdw_still_wait: got %b want 00", {imem_req_valid, inst_valid});
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hdead_beef;
    tick();
    imem_resp_valid = 1'b0;
    n_vec++;
    if ({imem_req_valid, inst_valid, imem_req_addr} !== {2'b10, 64'h8000_1000}) begin
      n_err++;
      $display("FAIL rdw_discard: got rq=%b v=%b a=%h want 1 0 80001000", imem_req_valid,
               inst_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0010_0093;
    tick();
    imem_resp_valid = 1'b0;
    n_vec++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0010_0093, 64'h8000_1000}) begin
      n_err++;
      $display("FAIL rdw_deliver: got v=%b i=%h pc=%h want 1 00100093 80001000", inst_valid,
               inst, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_vec++;
    if (imem_req_addr !== 64'h8000_1004) begin
      n_err++;
      $display("FAIL rdw_next: got %h want 80001004", imem_req_addr);
    end
  endtask

  task automatic test_redirect_resp_same();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hcafe_f00d;
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h8000_2000;
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    n_vec++;
    if ({imem_req_valid, inst_valid, imem_req_addr} !== {2'b10, 64'h8000_2000}) begin
      n_err++;
      $display("FAIL rds_drop: got rq=%b v=%b a=%h want 1 0 80002000", imem_req_valid,
               inst_valid, imem_req_addr);
    end
    tick();
    n_vec++;
    if (inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rds_no_valid: got %b want 0", inst_valid);
    end
  endtask

  task automatic test_resp_err();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0008;
    tick();
    redirect_valid = 1'b0;
    n_vec++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0008}) begin
      n_err++;
      $display("FAIL err_req_redirect: got rq=%b a=%h want 1 80000008", imem_req_valid,
               imem_req_addr);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_err   = 1'b1;
    imem_resp_data  = 32'hffff_ffff;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    n_vec++;
    if ({inst_valid, inst_fault, inst, inst_pc} !== {2'b11, 32'h0, 64'h8000_0008}) begin
      n_err++;
      $display("FAIL err_fault: got v=%b f=%b i=%h pc=%h want 1 1 0 80000008", inst_valid,
               inst_fault, inst, inst_pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_vec++;
    if (imem_req_addr !== 64'h8000_000c) begin
      n_err++;
      $display("FAIL err_next: got %h want 8000000c", imem_req_addr);
    end
  endtask

  task automatic test_redirect_hold();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b1;
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h8000_4000;
    tick();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    n_vec++;
    if ({inst_valid, imem_req_valid, imem_req_addr} !== {2'b01, 64'h8000_4000}) begin
      n_err++;
      $display("FAIL rdh_priority: got v=%b rq=%b a=%h want 0 1 80004000", inst_valid,
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0002;
    tick();
    redirect_valid = 1'b0;
    n_vec++;
    if ({imem_req_valid, inst_valid, inst_fault, inst, inst_pc}
        !== {3'b011, 32'h0, 64'h8000_0002}) begin
      n_err++;
      $display("FAIL mis_fault: got rq=%b v=%b f=%b i=%h pc=%h want 0 1 1 0 80000002",
               imem_req_valid, inst_valid, inst_fault, inst, inst_pc);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    n_vec++;
    if ({imem_req_valid, inst_valid} !== 2'b01) begin
      n_err++;
      $display("FAIL mis_no_req: got %b want 01", {imem_req_valid, inst_valid});
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_vec++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, 64'h8000_0006}) begin
      n_err++;
      $display("FAIL mis_consume: got rq=%b a=%h want 1 80000006", imem_req_valid,
               imem_req_addr);
    end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hffff_ffff_ffff_fffc;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    tick();
    n_vec++;
    if ({imem_req_valid, inst_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_wait: got %b want 00", {imem_req_valid, inst_valid});
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    n_vec++;
    if ({inst_valid, inst_pc} !== {1'b1, 64'hffff_ffff_ffff_fffc}) begin
      n_err++;
      $display("FAIL b2b_deliver: got v=%b pc=%h want 1 fffffffffffffffc", inst_valid, inst_pc);
    end
    tick();
    n_vec++;
    if ({imem_req_valid, inst_valid, imem_req_addr} !== {2'b10, 64'h0}) begin
      n_err++;
      $display("FAIL b2b_wrap: got rq=%b v=%b a=%h want 1 0 0", imem_req_valid, inst_valid,
               imem_req_addr);
    end
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
  endtask

  task automatic test_reset_mid();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_3000;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({imem_req_valid, inst_valid, imem_req_addr} !== {2'b00, 64'h8000_0000}) begin
      n_err++;
      $display("FAIL mid_rst_state: got rq=%b v=%b a=%h want 0 0 80000000", imem_req_valid,
               inst_valid, imem_req_addr);
    end
    n_vec++;
    if ({inst, inst_pc, inst_fault} !== 97'd0) begin
      n_err++;
      $display("FAIL mid_rst_outputs: got i=%h pc=%h f=%b want 0", inst, inst_pc, inst_fault);
    end
    tick();
    rst_n           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    tick();
    imem_resp_valid = 1'b0;
    n_vec++;
    if ({imem_req_valid, inst_valid, imem_req_addr} !== {2'b10, 64'h8000_0000}) begin
      n_err++;
      $display("FAIL mid_rst_stale: got rq=%b v=%b a=%h want 1 0 80000000", imem_req_valid,
               inst_valid, imem_req_addr);
    end
    tick();
    n_vec++;
    if (inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_no_valid: got %b want 0", inst_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_resp_same();
    test_resp_err();
    test_redirect_hold();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
